// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle: fetch requester, load/store requester
// and the single memory port, seen from the arbiter (slave) side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_we, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_we, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction
// fetch and load/store; reads wait MEM_LAT cycles for data.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    localparam logic [2:0] LAT3 = 3'(MEM_LAT);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rr_q, rr_d;
    logic        own_q, own_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic idle;
    logic can_gnt;
    logic gnt_d;
    logic gnt_f;
    logic mis;
    logic d_ok;
    logic rd_gnt;
    logic done;
    logic if_rv;
    logic d_rv;

    // Grant decision; rr==1 means fetch wins a tie, and no grant under reset.
    always_comb begin
        idle    = (state_q == IDLE);
        can_gnt = idle && rst;
        gnt_d   = can_gnt && bus.d_req && (!bus.if_req || !rr_q);
        gnt_f   = can_gnt && bus.if_req && !gnt_d;
        mis     = (bus.d_addr[1:0] != 2'b00);
        d_ok    = gnt_d && !mis;
        rd_gnt  = gnt_f || (d_ok && !bus.d_we);
        done    = !idle && rst && (cnt_q == 3'd1);
        if_rv   = done && own_q;
        d_rv    = done && !own_q;
    end

    // Drive the shared memory port only in a clean grant cycle.
    always_comb begin
        bus.mem_addr  = 32'd0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 32'd0;
        unique case (1'b1)
            gnt_f: begin
                bus.mem_addr = bus.if_addr;
            end
            d_ok: begin
                bus.mem_addr  = bus.d_addr;
                bus.mem_we    = bus.d_we;
                bus.mem_wdata = bus.d_wdata;
            end
            default: ;
        endcase
    end

    // Requester-facing outputs; rdata holds its last delivered word.
    always_comb begin
        bus.if_gnt    = gnt_f;
        bus.d_gnt     = gnt_d;
        bus.d_err     = gnt_d && mis;
        bus.if_rvalid = if_rv;
        bus.d_rvalid  = d_rv;
        bus.if_rdata  = if_rv ? bus.mem_rdata : if_rdata_q;
        bus.d_rdata   = d_rv ? bus.mem_rdata : d_rdata_q;
        bus.busy      = (state_q == WAIT);
    end

    // Next state: pointer flips to the loser, reads park in WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        own_d      = own_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (gnt_d) begin
            rr_d = 1'b1;
        end else if (gnt_f) begin
            rr_d = 1'b0;
        end
        if (rd_gnt) begin
            state_d = WAIT;
            cnt_d   = LAT3;
            own_d   = gnt_f;
        end else if (!idle) begin
            cnt_d = cnt_q - 3'd1;
            if (done) begin
                state_d = IDLE;
            end
        end
        if (if_rv) begin
            if_rdata_d = bus.mem_rdata;
        end
        if (d_rv) begin
            d_rdata_d = bus.mem_rdata;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            rr_q       <= 1'b0;
            own_q      <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            own_q      <= own_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-return scoreboard.
// Memory read data is a cycle stamp, so each return is predictable.
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    typedef struct {
        logic own;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic mon_on = 1'b0;
    exp_t q[$];
    logic [31:0] last_f = 32'd0;
    logic [31:0] last_d = 32'd0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MEM_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_rdata = {16'hA5C3, cyc[15:0]};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h",
                     tag, cyc, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_chk(input logic ef, input logic ed,
                             input logic ee, input logic eb);
        @(negedge clk);
        chk("if_gnt", 32'(bus.if_gnt), 32'(ef));
        chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
        chk("d_err", 32'(bus.d_err), 32'(ee));
        chk("busy", 32'(bus.busy), 32'(eb));
        if (!ef && !ed) begin
            chk("idle_mem_addr", bus.mem_addr, 32'd0);
            chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
            chk("idle_mem_wdata", bus.mem_wdata, 32'd0);
        end
    endtask

    task automatic wait_chk(input int n);
        for (int i = 0; i < n; i++) begin
            grant_chk(1'b0, 1'b0, 1'b0, 1'b1);
            nxt();
        end
    endtask

    task automatic push(input logic own);
        q.push_back('{own, cyc + LAT});
    endtask

    // Scoreboard: compare read returns and rdata hold every cycle.
    always @(negedge clk) begin
        logic        ev_f;
        logic        ev_d;
        logic [31:0] ed;
        if (mon_on) begin
            ev_f = 1'b0;
            ev_d = 1'b0;
            ed   = {16'hA5C3, cyc[15:0]};
            if (rst && q.size() > 0 && q[0].due == cyc) begin
                ev_f = q[0].own;
                ev_d = !q[0].own;
                void'(q.pop_front());
            end
            chk("if_rvalid", 32'(bus.if_rvalid), 32'(ev_f));
            chk("d_rvalid", 32'(bus.d_rvalid), 32'(ev_d));
            chk("if_rdata", bus.if_rdata, ev_f ? ed : last_f);
            chk("d_rdata", bus.d_rdata, ev_d ? ed : last_d);
            if (ev_f) last_f = ed;
            if (ev_d) last_d = ed;
            if (!rst) begin
                q.delete();
                last_f = 32'd0;
                last_d = 32'd0;
            end
        end
    end

    initial begin
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0200;
        bus.d_wdata = 32'd0;

        // Reset held with both requesting: nothing granted.
        nxt();
        mon_on = 1'b1;
        grant_chk(1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        grant_chk(1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        rst = 1'b1;

        // Both reading continuously: data, fetch, data, fetch.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                grant_chk(1'b0, 1'b1, 1'b0, 1'b0);
                chk("rd_addr_d", bus.mem_addr, 32'h200);
                chk("rd_we_d", 32'(bus.mem_we), 32'd0);
                push(1'b0);
            end else begin
                grant_chk(1'b1, 1'b0, 1'b0, 1'b0);
                chk("rd_addr_f", bus.mem_addr, 32'h40);
                chk("rd_we_f", 32'(bus.mem_we), 32'd0);
                push(1'b1);
            end
            nxt();
            if (i == 3) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
            wait_chk(LAT);
        end

        // Aligned write wins, completes at once; pending fetch next.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0100;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0044;
        grant_chk(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wr_addr", bus.mem_addr, 32'h100);
        chk("wr_we", 32'(bus.mem_we), 32'd1);
        chk("wr_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        nxt();
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        grant_chk(1'b1, 1'b0, 1'b0, 1'b0);
        chk("f_after_wr_addr", bus.mem_addr, 32'h44);
        chk("f_after_wr_we", 32'(bus.mem_we), 32'd0);
        push(1'b1);
        nxt();
        bus.if_req = 1'b0;
        wait_chk(LAT);

        // Misaligned write then misaligned read: gnt+err, no WAIT.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b1;
        bus.d_addr = 32'h0000_0102;
        grant_chk(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mis_wr_addr", bus.mem_addr, 32'd0);
        chk("mis_wr_we", 32'(bus.mem_we), 32'd0);
        nxt();
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0201;
        grant_chk(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mis_rd_addr", bus.mem_addr, 32'd0);
        nxt();

        // After a lone data grant rr favours fetch; odd fetch addr legal.
        bus.d_addr  = 32'h0000_0300;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0043;
        grant_chk(1'b1, 1'b0, 1'b0, 1'b0);
        chk("odd_f_addr", bus.mem_addr, 32'h43);
        push(1'b1);
        nxt();
        bus.if_req = 1'b0;
        wait_chk(LAT);
        grant_chk(1'b0, 1'b1, 1'b0, 1'b0);
        chk("d_after_f_addr", bus.mem_addr, 32'h300);
        push(1'b0);
        nxt();
        bus.d_req = 1'b0;
        wait_chk(LAT);

        // Data read then reset mid-WAIT: read abandoned, rr cleared.
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0400;
        grant_chk(1'b0, 1'b1, 1'b0, 1'b0);
        nxt();
        rst         = 1'b0;
        bus.d_addr  = 32'h0000_0404;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0080;
        grant_chk(1'b0, 1'b0, 1'b0, 1'b1);
        nxt();
        grant_chk(1'b0, 1'b0, 1'b0, 1'b0);
        nxt();
        rst = 1'b1;
        grant_chk(1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_addr", bus.mem_addr, 32'h404);
        push(1'b0);
        nxt();
        bus.d_req = 1'b0;
        wait_chk(LAT);
        grant_chk(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_f_addr", bus.mem_addr, 32'h80);
        push(1'b1);
        nxt();
        bus.if_req = 1'b0;
        wait_chk(LAT);
        grant_chk(1'b0, 1'b0, 1'b0, 1'b0);
        nxt();

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d pending expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
